// File: rtl/adc_serial_reader.sv
// adc_serial_reader
//   Runs one conversion frame on a 3-wire SPI-style ADC, such as the
//   ADC128S022 on DE-series boards.
//   For each frame it:
//     - sends the 3-bit mux address on adcDin during SCLK periods 2..4;
//     - shifts in FRAME_BITS bits from adcDout, MSB first;
//     - keeps the low DATA_BITS bits of that frame as the result.
//
// Parameters
//   HALF_DIV   : CLOCK_50 cycles per SCLK half period (1..255)
//   DATA_BITS  : result width, taken from the LSB end of the frame
//   FRAME_BITS : SCLK periods per frame (>= DATA_BITS+3)
//
// Ports
//   CLOCK_50    in   system clock
//   resetN      in   synchronous active-low reset
//   start       in   conversion request, accepted only while idle
//   channel[3]  in   mux address, latched when start is accepted
//   adcDout     in   serial data from the ADC
//   adcCsN      out  chip select, active low
//   adcSclk     out  serial clock, idles high
//   adcDin      out  serial address bits to the ADC
//   sample      out  last completed result, held between conversions
//   sampleValid out  one-cycle pulse when sample updates
//   busy        out  high whenever a frame is in progress
module adc_serial_reader #(
  parameter int HALF_DIV   = 2,
  parameter int DATA_BITS  = 12,
  parameter int FRAME_BITS = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 resetN,
  input  logic                 start,
  input  logic [2:0]           channel,
  input  logic                 adcDout,
  output logic                 adcCsN,
  output logic                 adcSclk,
  output logic                 adcDin,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sampleValid,
  output logic                 busy
);

  localparam int HW = $clog2(HALF_DIV) + 1;
  localparam int PW = $clog2(FRAME_BITS) + 1;
  localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t               state;
  logic [HW-1:0]        halfCnt;
  logic [PW-1:0]        perCnt;
  logic [2:0]           chanReg;
  logic [DATA_BITS-1:0] shiftReg;

  // Address bit presented while SCLK is low in period p.
  // The ADC samples this bit on the following rising edge.
  function automatic logic addrBit(input logic [PW-1:0] p, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    if (p == PW'(2)) b = ch[2];
    if (p == PW'(3)) b = ch[1];
    if (p == PW'(4)) b = ch[0];
    return b;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      state       <= IDLE;
      halfCnt     <= '0;
      perCnt      <= '0;
      chanReg     <= '0;
      shiftReg    <= '0;
      adcCsN      <= 1'b1;
      adcSclk     <= 1'b1;
      adcDin      <= 1'b0;
      sample      <= '0;
      sampleValid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      case (state)
        IDLE: begin
          adcCsN  <= 1'b1;
          adcSclk <= 1'b1;
          adcDin  <= 1'b0;
          halfCnt <= '0;
          perCnt  <= '0;
          if (start) begin
            chanReg  <= channel;
            shiftReg <= '0;
            adcCsN   <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (halfCnt == H_LAST) begin
            // The first falling SCLK edge opens period 0.
            halfCnt <= '0;
            perCnt  <= '0;
            adcSclk <= 1'b0;
            adcDin  <= addrBit('0, chanReg);
            state   <= SHIFT;
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        SHIFT: begin
          if (halfCnt != H_LAST) begin
            halfCnt <= halfCnt + 1'b1;
          end else begin
            halfCnt <= '0;
            if (!adcSclk) begin
              // End of the low phase: SCLK rises, so capture the data bit.
              // Keeping only DATA_BITS bits drops the leading frame bits.
              adcSclk  <= 1'b1;
              shiftReg <= {shiftReg[DATA_BITS-2:0], adcDout};
            end else if (perCnt == P_LAST) begin
              // Last high phase is done. SCLK stays high and CS is released.
              adcCsN <= 1'b1;
              adcDin <= 1'b0;
              state  <= DONE;
            end else begin
              perCnt  <= perCnt + 1'b1;
              adcSclk <= 1'b0;
              adcDin  <= addrBit(perCnt + 1'b1, chanReg);
            end
          end
        end
        DONE: begin
          if (halfCnt == '0) begin
            sample      <= shiftReg;
            sampleValid <= 1'b1;
          end
          if (halfCnt == H_LAST) begin
            halfCnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            halfCnt <= halfCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Bench for adc_serial_reader. It runs two instances side by side:
//   dut0 with HALF_DIV=2 and dut1 with HALF_DIV=1.
// A behavioural ADC serves frames from a per-instance queue.
// It also records the address bits seen on each SCLK period, the gap
// between frames, and every sampleValid pulse.
module tb_adc_serial_reader;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start [2];
  logic [2:0]  ch [2];
  logic        dout [2];
  logic        csN [2];
  logic        sclk [2];
  logic        dinP [2];
  logic [11:0] smp [2];
  logic        vld [2];
  logic        busy [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_serial_reader #(.HALF_DIV(2), .DATA_BITS(12), .FRAME_BITS(16)) dut0 (
    .CLOCK_50(clk), .resetN(resetN), .start(start[0]), .channel(ch[0]),
    .adcDout(dout[0]), .adcCsN(csN[0]), .adcSclk(sclk[0]), .adcDin(dinP[0]),
    .sample(smp[0]), .sampleValid(vld[0]), .busy(busy[0]));

  adc_serial_reader #(.HALF_DIV(1), .DATA_BITS(12), .FRAME_BITS(16)) dut1 (
    .CLOCK_50(clk), .resetN(resetN), .start(start[1]), .channel(ch[1]),
    .adcDout(dout[1]), .adcCsN(csN[1]), .adcSclk(sclk[1]), .adcDin(dinP[1]),
    .sample(smp[1]), .sampleValid(vld[1]), .busy(busy[1]));

  // ---------------- ADC model and monitors ----------------
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] cur [2];
  logic [15:0] dinRec [2];
  logic [15:0] vldDin [2];
  logic [11:0] vHist [2][64];
  int          gapHist [2][64];
  int          per [2];
  int          run [2];
  int          fCnt [2];
  int          vldCnt [2];
  int          vldCyc [2];
  int          vldPer [2];
  logic        prevCs [2];
  logic        prevSclk [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      dout[i] = 1'b0; start[i] = 1'b0; ch[i] = 3'd0;
      cur[i] = '0; dinRec[i] = '0; vldDin[i] = '0;
      per[i] = 0; run[i] = 0; fCnt[i] = 0; vldCnt[i] = 0; vldCyc[i] = 0; vldPer[i] = 0;
      prevCs[i] = 1'b1; prevSclk[i] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!csN[i] && prevCs[i]) begin
        cur[i] = 16'h0;
        if (i == 0) begin
          if (q0.size() > 0) cur[i] = q0.pop_front();
        end else begin
          if (q1.size() > 0) cur[i] = q1.pop_front();
        end
        per[i] = 0;
        dinRec[i] = '0;
        gapHist[i][fCnt[i] % 64] = run[i];
        fCnt[i]++;
      end
      run[i] = csN[i] ? run[i] + 1 : 0;
      // Each falling SCLK opens a new period.
      // The ADC presents the next frame bit, MSB first.
      if (!csN[i] && prevSclk[i] && !sclk[i]) begin
        if (per[i] < 16) begin
          dout[i] = cur[i][15 - per[i]];
          dinRec[i][per[i]] = dinP[i];
        end
        per[i]++;
      end
      if (vld[i]) begin
        vHist[i][vldCnt[i] % 64] = smp[i];
        vldCnt[i]++;
        vldCyc[i] = cyc;
        vldPer[i] = per[i];
        vldDin[i] = dinRec[i];
      end
      prevCs[i] = csN[i];
      prevSclk[i] = sclk[i];
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pushF(input int i, input logic [15:0] f);
    if (i == 0) q0.push_back(f); else q1.push_back(f);
  endtask

  // Reference rules for one conversion:
  //   result  = low 12 bits of the frame
  //   address = channel bits on periods 2,3,4 (MSB first)
  //   latency = 33*HALF_DIV+1
  function automatic logic [15:0] dinOf(input logic [2:0] c);
    logic [15:0] d;
    d = '0;
    d[2] = c[2];
    d[3] = c[1];
    d[4] = c[0];
    return d;
  endfunction

  task automatic runConv(input int i, input logic [2:0] c, input logic [15:0] f,
                         input logic [11:0] es, input logic [15:0] ed, input int el,
                         input string tag);
    int n0;
    int acc;
    n0 = vldCnt[i];
    pushF(i, f);
    start[i] = 1'b1;
    ch[i] = c;
    acc = cyc + 1;
    tick();
    start[i] = 1'b0;
    ch[i] = ~c;   // must not disturb the frame in flight
    for (int k = 0; k < 400 && vldCnt[i] == n0; k++) tick();
    if (vldCnt[i] == n0) begin
      chk({tag, " timeout"}, 0, 1);
    end else begin
      chk({tag, " sample"}, vHist[i][n0 % 64], es);
      chk({tag, " din"}, vldDin[i], ed);
      chk({tag, " latency"}, vldCyc[i] - acc, el);
      chk({tag, " periods"}, vldPer[i], 16);
      repeat (4) tick();
      chk({tag, " pulses"}, vldCnt[i] - n0, 1);
    end
  endtask

  typedef struct {
    int          inst;
    logic [2:0]  chn;
    logic [15:0] frame;
    logic [11:0] expSample;
    logic [15:0] expDin;
    int          expLat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n0;
    int f0;
    int acc;
    int bad;
    logic [2:0] c;
    logic [15:0] f;
    int i;

    tbl[0] = '{0, 3'd5, 16'h0ABC, 12'hABC, 16'h0014, 67};
    tbl[1] = '{1, 3'd5, 16'h05A5, 12'h5A5, 16'h0014, 34};
    tbl[2] = '{0, 3'd3, 16'hF000, 12'h000, 16'h0018, 67};
    tbl[3] = '{1, 3'd6, 16'h0FFF, 12'hFFF, 16'h000C, 34};
    tbl[4] = '{0, 3'd0, 16'h0001, 12'h001, 16'h0000, 67};
    tbl[5] = '{1, 3'd7, 16'h8800, 12'h800, 16'h001C, 34};

    // Reset state
    resetN = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst csN", csN[k], 1);
      chk("rst sclk", sclk[k], 1);
      chk("rst din", dinP[k], 0);
      chk("rst sample", smp[k], 0);
      chk("rst valid", vld[k], 0);
      chk("rst busy", busy[k], 0);
    end
    resetN = 1'b1;
    tick();

    // Table-driven conversions
    for (int t = 0; t < 6; t++)
      runConv(tbl[t].inst, tbl[t].chn, tbl[t].frame, tbl[t].expSample,
              tbl[t].expDin, tbl[t].expLat, $sformatf("vec%0d", t));

    // Randomised conversions on either instance
    for (int r = 0; r < 12; r++) begin
      i = int'($urandom_range(1, 0));
      c = 3'($urandom);
      f = 16'($urandom);
      runConv(i, c, f, f[11:0], dinOf(c), 33 * (i == 0 ? 2 : 1) + 1,
              $sformatf("rnd%0d", r));
    end

    // Start pulse while busy is ignored
    n0 = vldCnt[0];
    bad = 0;
    pushF(0, 16'h0123);
    start[0] = 1'b1; ch[0] = 3'd2;
    tick();
    start[0] = 1'b0;
    repeat (9) begin
      if (!busy[0]) bad++;
      tick();
    end
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 300 && vldCnt[0] == n0; k++) begin
      if (!busy[0]) bad++;
      tick();
    end
    chk("ign busyhigh", bad, 0);
    chk("ign sample", smp[0], 12'h123);
    f0 = fCnt[0];
    repeat (150) tick();
    chk("ign pulses", vldCnt[0] - n0, 1);
    chk("ign noframe", fCnt[0] - f0, 0);

    // Continuous start: three back-to-back frames
    n0 = vldCnt[0];
    f0 = fCnt[0];
    pushF(0, 16'h0001); pushF(0, 16'h0800); pushF(0, 16'h0FFF);
    start[0] = 1'b1; ch[0] = 3'd1;
    for (int k = 0; k < 600 && vldCnt[0] < n0 + 3; k++) tick();
    start[0] = 1'b0;
    repeat (200) tick();
    chk("cont pulses", vldCnt[0] - n0, 3);
    chk("cont v0", vHist[0][n0 % 64], 12'h001);
    chk("cont v1", vHist[0][(n0 + 1) % 64], 12'h800);
    chk("cont v2", vHist[0][(n0 + 2) % 64], 12'hFFF);
    chk("cont gap1", gapHist[0][(f0 + 1) % 64], 3);
    chk("cont gap2", gapHist[0][(f0 + 2) % 64], 3);

    // Reset at SCLK period 7 aborts the frame
    n0 = vldCnt[0];
    pushF(0, 16'h0ABC);
    start[0] = 1'b1; ch[0] = 3'd4;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 200 && per[0] < 8; k++) tick();
    chk("mrst reached p7", per[0], 8);
    resetN = 1'b0;
    tick();
    chk("mrst csN", csN[0], 1);
    chk("mrst sclk", sclk[0], 1);
    chk("mrst busy", busy[0], 0);
    chk("mrst sample", smp[0], 0);
    chk("mrst valid", vld[0], 0);
    resetN = 1'b1;
    repeat (150) tick();
    chk("mrst nopulse", vldCnt[0] - n0, 0);

    // Reset and start together: reset wins, then start is taken
    resetN = 1'b0;
    start[0] = 1'b1; ch[0] = 3'd3;
    repeat (3) tick();
    chk("rs busy", busy[0], 0);
    chk("rs csN", csN[0], 1);
    n0 = vldCnt[0];
    pushF(0, 16'h0777);
    resetN = 1'b1;
    acc = cyc + 1;
    tick();
    start[0] = 1'b0;
    chk("rs accepted", busy[0], 1);
    for (int k = 0; k < 300 && vldCnt[0] == n0; k++) tick();
    chk("rs sample", vHist[0][n0 % 64], 12'h777);
    chk("rs latency", vldCyc[0] - acc, 67);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_reader.md
ADC_SERIAL_READER -- requirements
Module: adc_serial_reader

Interface
REQ-001 SHALL have parameter HALF_DIV, default 2, meaning the number of CLOCK_50 cycles per SCLK half-period; legal values are 1 to 255.
REQ-002 SHALL have parameter DATA_BITS, default 12, meaning the number of converted result bits, taken from the LSB end of the frame.
REQ-003 SHALL have parameter FRAME_BITS, default 16, meaning the number of SCLK periods per conversion frame; FRAME_BITS SHALL be at least DATA_BITS+3.
REQ-004 CLOCK_50  in  1  the single system clock; all state updates on its rising edge.
REQ-005 resetN  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  conversion request, sampled only in IDLE.
REQ-007 channel  in  3  ADC input-mux address, latched when start is accepted.
REQ-008 adcDout  in  1  serial data from the ADC.
REQ-009 adcCsN  out  1  ADC chip select, active-low.
REQ-010 adcSclk  out  1  serial clock to the ADC; idles high.
REQ-011 adcDin  out  1  serial address bits to the ADC.
REQ-012 sample  out  DATA_BITS  last completed conversion result.
REQ-013 sampleValid  out  1  one-cycle pulse when sample updates.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, SETUP, SHIFT and DONE, and SHALL drive all outputs from registers.
REQ-016 IDLE SHALL drive adcCsN=1, adcSclk=1 and adcDin=0; when start=1 it SHALL latch channel, clear the shift register and move to SETUP.
REQ-017 SETUP SHALL drive adcCsN=0 and adcSclk=1 for HALF_DIV cycles, then move to SHIFT.
REQ-018 SHIFT SHALL generate FRAME_BITS SCLK periods, each HALF_DIV cycles low followed by HALF_DIV cycles high, using a half-period counter of width clog2(HALF_DIV)+1 that wraps to 0 at HALF_DIV-1.
REQ-019 On the cycle where adcSclk goes 0->1, the block SHALL shift adcDout into the shift register LSB, MSB-first.
REQ-020 On the cycle where adcSclk goes 1->0 for period index p (0-based), the block SHALL drive adcDin as follows: ADD2 for p=2, ADD1 for p=3, ADD0 for p=4, and 0 for all other p.
REQ-021 After the high phase of period FRAME_BITS-1 completes, the FSM SHALL move to DONE.
REQ-022 DONE SHALL drive adcCsN=1 and adcSclk=1 for HALF_DIV cycles; on the first DONE cycle it SHALL load sample with shift[DATA_BITS-1:0] and pulse sampleValid for exactly one cycle; it SHALL then return to IDLE.
REQ-023 Latency SHALL be 33*HALF_DIV+1 cycles from the start-accept edge to the sampleValid cycle (67 cycles at the default HALF_DIV).
REQ-024 sample SHALL hold its value between conversions.
REQ-025 start while busy=1 SHALL be ignored, neither queued nor acknowledged.
REQ-026 start held high continuously SHALL produce back-to-back frames, with adcCsN high for HALF_DIV+1 cycles between frames.
REQ-027 A change on channel mid-frame SHALL NOT affect adcDin for the current frame.
REQ-028 The upper FRAME_BITS-DATA_BITS received bits SHALL be discarded.
REQ-029 The period counter SHALL be clog2(FRAME_BITS)+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-030 When resetN=0 at a clock edge, the block SHALL enter IDLE on that edge regardless of state.
REQ-031 Reset SHALL set adcCsN=1, adcSclk=1, adcDin=0, sample=0, sampleValid=0, busy=0, and clear the counters and shift register.
REQ-032 Reset mid-frame SHALL abort the frame without a sampleValid pulse, and sample SHALL read 0.
REQ-033 With resetN=0 and start=1 together, reset SHALL win, and no frame SHALL begin until start is seen with resetN=1.

Verification
REQ-034 Single conversion: HALF_DIV=2, channel=5, ADC model returning 0xABC -> 16 SCLK periods are generated, adcDin carries bits 1,0,1 on periods 2-4, sample=0xABC with a sampleValid pulse 67 cycles after start.
REQ-035 Busy ignore: a start pulse issued at cycle 10 of an active frame -> exactly one sampleValid, busy stays high throughout, no extra frame follows.
REQ-036 Continuous start: start held high for 3 frames with data 0x001, 0x800 and 0xFFF -> three pulses with those values, adcCsN high for 3 cycles between frames.
REQ-037 Mid-frame reset: resetN=0 at SCLK period 7 -> the next cycle shows adcCsN=1, adcSclk=1, busy=0, sample=0, and no sampleValid.
REQ-038 HALF_DIV=1: a conversion returning 0x5A5 -> SCLK toggles every cycle, sampleValid arrives 34 cycles after start, sample=0x5A5.
REQ-039 Leading-bit discard: the ADC drives 1 on frame bits 0-3 with data 0x000 -> sample=0x000.
